// File: rtl/st_fwd_buffer_pkg.sv
// Shared types for the store-forwarding buffer: the entry record and the age
// helpers used by the youngest-entry selector and the one-hot read mux.
package st_fwd_buffer_pkg;

    // Entry field widths; the top-level parameter defaults track these values.
    localparam int E_DATA_W   = 32;
    localparam int E_ADDR_W   = 32;
    localparam int E_R_W      = 6;
    localparam int E_UOP_W    = 5;
    localparam int E_TICKET_W = 3;
    localparam int E_BE_W     = E_DATA_W / 8;

    typedef struct packed {
        logic [E_ADDR_W-1:0]   addr;
        logic [E_DATA_W-1:0]   data;
        logic [E_BE_W-1:0]     be;
        logic [E_UOP_W-1:0]    microop;
        logic [E_R_W-1:0]      dest;
        logic [E_TICKET_W-1:0] ticket;
        logic                  isfetched;
    } entry_t;

    // Distance of slot idx from the head slot; larger means younger.
    function automatic int unsigned age_of(input int unsigned idx,
                                           input int unsigned head,
                                           input int unsigned depth);
        return (idx + depth - head) % depth;
    endfunction

    // One AND-OR mux leg: passes the entry only when its select bit is set.
    function automatic entry_t and_or_mux(input entry_t e, input logic sel);
        return sel ? e : '0;
    endfunction

endpackage

// File: rtl/st_fwd_age_sel.sv
// Picks the youngest set bit of a DEPTH-wide mask, where age is measured from
// the FIFO head slot; returns it one-hot.
module st_fwd_age_sel
    import st_fwd_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] mask,
    input  logic [PTR_W-1:0] head,
    output logic [DEPTH-1:0] onehot,
    output logic             any
);

    int unsigned best;

    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    always_comb begin
        onehot = '0;
        any    = 1'b0;
        best   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mask[i] && (!any || age_of(32'(i), 32'(head), 32'(DEPTH)) > best)) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                best      = age_of(32'(i), 32'(head), 32'(DEPTH));
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/st_fwd_buffer.sv
// Store buffer: in-order FIFO of pending stores with same-cycle load
// forwarding search, block-granular fetch-status update and flush.
module st_fwd_buffer
    import st_fwd_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = E_DATA_W,
    parameter int ADDR_BITS      = E_ADDR_W,
    parameter int BLOCK_ID_START = 5,
    parameter int R_WIDTH        = E_R_W,
    parameter int MICROOP        = E_UOP_W,
    parameter int ROB_TICKET     = E_TICKET_W,
    parameter int DEPTH          = 8,
    localparam int BE_W          = DATA_WIDTH / 8,
    localparam int OFS           = $clog2(BE_W),
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ADDR_BITS-1:0]  push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [BE_W-1:0]       push_be,
    input  logic [MICROOP-1:0]    push_microop,
    input  logic [R_WIDTH-1:0]    push_dest,
    input  logic [ROB_TICKET-1:0] push_ticket,
    input  logic                  push_isfetched,
    input  logic [ADDR_BITS-1:0]  search_addr,
    input  logic [BE_W-1:0]       search_be,
    output logic                  search_hit,
    output logic                  search_conflict,
    output logic                  search_block_hit,
    output logic [DATA_WIDTH-1:0] search_data,
    output logic [ROB_TICKET-1:0] search_ticket,
    input  logic                  update_valid,
    input  logic [ADDR_BITS-1:0]  update_addr,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  head_valid,
    output logic                  head_isfetched,
    output logic [ADDR_BITS-1:0]  head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [BE_W-1:0]       head_be,
    output logic [MICROOP-1:0]    head_microop,
    output logic [R_WIDTH-1:0]    head_dest,
    output logic [ROB_TICKET-1:0] head_ticket,
    output logic                  ready,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow_err
);

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head_ptr, tail_ptr;

    logic             push_acc, pop_acc, push_upd, any_overlap;
    logic [DEPTH-1:0] overlap, block_match, upd_match, sel_oh;
    entry_t           sel_e, head_e;

    assign ready      = (count != CNT_W'(DEPTH));
    assign head_valid = (count != '0);
    assign push_acc   = push & (ready | pop);
    assign pop_acc    = pop & head_valid;
    assign push_upd   = update_valid &&
        (push_addr[ADDR_BITS-1:BLOCK_ID_START] == update_addr[ADDR_BITS-1:BLOCK_ID_START]);

    always_comb begin
        overlap     = '0;
        block_match = '0;
        upd_match   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            overlap[i] = valid[i]
                && (mem[i].addr[ADDR_BITS-1:OFS] == search_addr[ADDR_BITS-1:OFS])
                && |(mem[i].be & search_be);
            block_match[i] = valid[i]
                && (mem[i].addr[ADDR_BITS-1:BLOCK_ID_START] == search_addr[ADDR_BITS-1:BLOCK_ID_START]);
            upd_match[i] = update_valid && valid[i]
                && (mem[i].addr[ADDR_BITS-1:BLOCK_ID_START] == update_addr[ADDR_BITS-1:BLOCK_ID_START]);
        end
    end

    st_fwd_age_sel #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_age_sel (
        .mask   (overlap),
        .head   (head_ptr),
        .onehot (sel_oh),
        .any    (any_overlap)
    );

    always_comb begin
        sel_e = '0;
        for (int i = 0; i < DEPTH; i++)
            sel_e = entry_t'(sel_e | and_or_mux(mem[i], sel_oh[i]));
    end

    // The youngest overlapping store must supply every requested byte, else the load stalls.
    assign search_hit       = any_overlap && ((sel_e.be & search_be) == search_be);
    assign search_conflict  = any_overlap && !search_hit;
    assign search_block_hit = |block_match;
    assign search_data      = search_hit ? sel_e.data   : '0;
    assign search_ticket    = search_hit ? sel_e.ticket : '0;

    assign head_e         = head_valid ? mem[head_ptr] : '0;
    assign head_isfetched = head_e.isfetched;
    assign head_addr      = head_e.addr;
    assign head_data      = head_e.data;
    assign head_be        = head_e.be;
    assign head_microop   = head_e.microop;
    assign head_dest      = head_e.dest;
    assign head_ticket    = head_e.ticket;

    // Bits the selector reads but the outputs do not need.
    logic unused_bits;
    assign unused_bits = ^{search_addr[OFS-1:0], update_addr[BLOCK_ID_START-1:0],
                           sel_e.addr, sel_e.microop, sel_e.dest, sel_e.isfetched};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid        <= '0;
            head_ptr     <= '0;
            tail_ptr     <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
            // NOTE: only control state is reset; payload fields stay unreset since valid gates every read.
            for (int i = 0; i < DEPTH; i++)
                mem[i].isfetched <= 1'b0;
        end else begin
            if (push && !push_acc && !flush)
                overflow_err <= 1'b1;
            if (flush) begin
                valid    <= '0;
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++)
                    if (upd_match[i])
                        mem[i].isfetched <= 1'b1;
                if (pop_acc) begin
                    valid[head_ptr] <= 1'b0;
                    head_ptr        <= head_ptr + 1'b1;
                end
                // Push after pop so a full-buffer push+pop leaves the recycled slot valid.
                if (push_acc) begin
                    mem[tail_ptr] <= '{addr: push_addr, data: push_data, be: push_be,
                                       microop: push_microop, dest: push_dest,
                                       ticket: push_ticket,
                                       isfetched: push_isfetched | push_upd};
                    valid[tail_ptr] <= 1'b1;
                    tail_ptr        <= tail_ptr + 1'b1;
                end
                count <= count + CNT_W'(push_acc) - CNT_W'(pop_acc);
            end
        end
    end

endmodule
